// File: rtl/can_frame_tx_if.sv
// CAN transmit serializer port bundle: request, frame fields, bit strobe and serial status.
// Latency: none, wires only.
// Backpressure: none; start is a one-cycle request, honoured only while the serializer is idle.
interface can_frame_tx_if;
    logic        enable;
    logic        start;
    logic [10:0] msgId;
    logic [3:0]  msgSize;
    logic [63:0] dataIn;
    logic        bitPulse;
    logic        dOut;
    logic        busy;
    logic        completeTx;
    logic        stuffBit;

    modport master (
        output enable, start, msgId, msgSize, dataIn, bitPulse,
        input  dOut, busy, completeTx, stuffBit
    );

    modport slave (
        input  enable, start, msgId, msgSize, dataIn, bitPulse,
        output dOut, busy, completeTx, stuffBit
    );
endinterface

// File: rtl/can_frame_tx.sv
// CAN frame serializer: SOF, ID, RTR/IDE/r0, DLC and data with bit stuffing; optional CRC-15 and delimiter under CAN_CRC_EN.
// Latency: SOF is driven on the first bitPulse after an accepted start; each later bit takes one bitPulse.
// Backpressure: start is ignored while busy or disabled; busy stays high until the completeTx pulse.
module can_frame_tx #(
    parameter int MAX_BYTES = 8,
    parameter int STUFF_RUN = 5
) (
    input  logic           clk,
    input  logic           reset,
    can_frame_tx_if.slave  bus
);

    typedef enum logic [2:0] {
        s_idle,
        s_field,
        s_crc,
        s_delim,
        s_done
    } state_t;

    localparam int FRAME_W = 83;  // SOF + ID + RTR/IDE/r0 + DLC + 64 data bits

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;   // shifts left; MSB is the next field bit
    logic [6:0]           len_q, len_d;       // unstuffed field length, 19 + 8*N
    logic [6:0]           bit_ptr_q, bit_ptr_d;
    logic [2:0]           run_len_q, run_len_d;
    logic                 last_bit_q, last_bit_d;
    logic                 dout_q, dout_d;
    logic                 stuff_q, stuff_d;
`ifdef CAN_CRC_EN
    logic [14:0]          crc_q, crc_d;
`endif

    logic [3:0]           nbytes;
    logic [6:0]           seg_len;
    logic                 next_bit;

    // Next-state: accept a request, then emit one field, stuff, CRC or delimiter bit per bitPulse.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        len_d      = len_q;
        bit_ptr_d  = bit_ptr_q;
        run_len_d  = run_len_q;
        last_bit_d = last_bit_q;
        dout_d     = dout_q;
        stuff_d    = stuff_q;
`ifdef CAN_CRC_EN
        crc_d      = crc_q;
`endif
        nbytes     = (bus.msgSize > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : bus.msgSize;
        seg_len    = (state_q == s_crc) ? 7'd15 : len_q;
        next_bit   = frame_q[FRAME_W-1];
`ifdef CAN_CRC_EN
        if (state_q == s_crc) begin
            next_bit = crc_q[14];
        end
`endif

        case (state_q)
            s_idle: begin
                if (bus.enable && bus.start) begin
                    frame_d    = {1'b0, bus.msgId, 3'b000, bus.msgSize, bus.dataIn};
                    len_d      = 7'd19 + {nbytes, 3'b000};
                    bit_ptr_d  = 7'd0;
                    // lastBit=1 so SOF (dominant) always opens a fresh run
                    run_len_d  = 3'd0;
                    last_bit_d = 1'b1;
`ifdef CAN_CRC_EN
                    crc_d      = 15'd0;
`endif
                    state_d    = s_field;
                end
            end

            s_field, s_crc: begin
                if (bus.bitPulse) begin
                    if (run_len_q == 3'(STUFF_RUN)) begin
                        // Complement stuff bit; it starts a new run and the pointer holds.
                        dout_d     = ~last_bit_q;
                        last_bit_d = ~last_bit_q;
                        run_len_d  = 3'd1;
                        stuff_d    = 1'b1;
                    end else if (bit_ptr_q < seg_len) begin
                        dout_d     = next_bit;
                        last_bit_d = next_bit;
                        run_len_d  = (next_bit == last_bit_q) ? run_len_q + 3'd1 : 3'd1;
                        stuff_d    = 1'b0;
                        bit_ptr_d  = bit_ptr_q + 7'd1;
                        if (state_q == s_field) begin
                            frame_d = {frame_q[FRAME_W-2:0], 1'b0};
`ifdef CAN_CRC_EN
                            crc_d = {crc_q[13:0], 1'b0} ^
                                    ((next_bit ^ crc_q[14]) ? 15'h4599 : 15'h0000);
                            // CRC follows the data seamlessly; stuffing continues across the boundary
                            if (bit_ptr_q + 7'd1 == len_q) begin
                                bit_ptr_d = 7'd0;
                                state_d   = s_crc;
                            end
`endif
                        end
`ifdef CAN_CRC_EN
                        else begin
                            crc_d = {crc_q[13:0], 1'b0};
                        end
`endif
                    end else begin
                        // Segment done and no stuff pending.
                        dout_d  = 1'b1;
                        stuff_d = 1'b0;
`ifdef CAN_CRC_EN
                        state_d = s_delim;  // delimiter is recessive and leaves runLen alone
`else
                        state_d = s_done;
`endif
                    end
                end
            end

            s_delim: begin
                if (bus.bitPulse) begin
                    dout_d  = 1'b1;
                    stuff_d = 1'b0;
                    state_d = s_done;
                end
            end

            s_done: begin
                state_d = s_idle;
            end

            default: begin
                state_d = s_idle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= s_idle;
            frame_q    <= '0;
            len_q      <= '0;
            bit_ptr_q  <= '0;
            run_len_q  <= '0;
            last_bit_q <= 1'b1;
            dout_q     <= 1'b1;
            stuff_q    <= 1'b0;
`ifdef CAN_CRC_EN
            crc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            len_q      <= len_d;
            bit_ptr_q  <= bit_ptr_d;
            run_len_q  <= run_len_d;
            last_bit_q <= last_bit_d;
            dout_q     <= dout_d;
            stuff_q    <= stuff_d;
`ifdef CAN_CRC_EN
            crc_q      <= crc_d;
`endif
        end
    end

    assign bus.dOut       = dout_q;
    assign bus.stuffBit   = stuff_q;
    assign bus.completeTx = (state_q == s_done);
    assign bus.busy       = (state_q != s_idle) && (state_q != s_done);

endmodule

// File: tb/tb_can_frame_tx.sv
// Testbench for can_frame_tx: table vectors from hand-derived frames, corner sequences,
// and random frames against a queue-based reference of the CAN framing and stuffing rules.
// Define CAN_CRC_EN for both bench and design to cover the CRC build.
module tb_can_frame_tx;
    localparam int MAX_BYTES = 8;
    localparam int STUFF_RUN = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    can_frame_tx_if bus();

    can_frame_tx #(.MAX_BYTES(MAX_BYTES), .STUFF_RUN(STUFF_RUN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: build the unstuffed bit list, optionally append CRC by long division,
    // then insert a complement after every window of STUFF_RUN equal emitted bits.
    function automatic void model(input logic [10:0] id, input logic [3:0] sz, input logic [63:0] d,
                                  output logic [127:0] eb, output logic [127:0] es, output int n);
        bit raw[$];
        bit outq[$];
        bit stq[$];
        int nb;
        bit all_eq;
        nb = (int'(sz) > MAX_BYTES) ? MAX_BYTES : int'(sz);
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        for (int i = 0; i < 3; i++) raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(sz[i]);
        for (int i = 0; i < 8 * nb; i++) raw.push_back(d[63-i]);
`ifdef CAN_CRC_EN
        begin
            bit rem[$];
            logic [15:0] poly;
            int rsz;
            poly = 16'hC599;
            rsz = raw.size();
            rem = raw;
            for (int i = 0; i < 15; i++) rem.push_back(1'b0);
            for (int i = 0; i < rsz; i++)
                if (rem[i]) for (int j = 0; j < 16; j++) rem[i+j] = rem[i+j] ^ poly[15-j];
            for (int i = 0; i < 15; i++) raw.push_back(rem[rsz+i]);
        end
`endif
        foreach (raw[i]) begin
            outq.push_back(raw[i]);
            stq.push_back(1'b0);
            if (outq.size() >= STUFF_RUN) begin
                all_eq = 1'b1;
                for (int j = 1; j < STUFF_RUN; j++)
                    if (outq[outq.size()-1-j] != raw[i]) all_eq = 1'b0;
                if (all_eq) begin
                    outq.push_back(!raw[i]);
                    stq.push_back(1'b1);
                end
            end
        end
`ifdef CAN_CRC_EN
        outq.push_back(1'b1);
        stq.push_back(1'b0);
`endif
        eb = '0;
        es = '0;
        n  = outq.size();
        for (int i = 0; i < n && i < 128; i++) begin
            eb[i] = outq[i];
            es[i] = stq[i];
        end
    endfunction

    // Send one frame and capture dOut/stuffBit after every bitPulse until completeTx.
    task automatic run_frame(input logic [10:0] id, input logic [3:0] sz, input logic [63:0] d,
                             input int gap, input int poke_at,
                             output logic [127:0] bits, output logic [127:0] stf, output int n);
        bit   stable;
        bit   ok;
        logic last;
        int   g;
        bits = '0; stf = '0; n = 0; ok = 1'b0; stable = 1'b1;
        @(negedge clk);
        bus.enable = 1'b1; bus.msgId = id; bus.msgSize = sz; bus.dataIn = d; bus.start = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.msgId   = 11'($urandom);
        bus.msgSize = 4'($urandom);
        bus.dataIn  = {$urandom, $urandom};
        check("busy_after_start", 128'(bus.busy), 128'(1));
        check("dout_before_sof", 128'(bus.dOut), 128'(1));
        last = bus.dOut;
        for (int k = 0; k < 200; k++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            for (int c = 0; c < g; c++) begin
                bus.bitPulse = 1'b0;
                @(negedge clk);
                if (bus.dOut !== last) stable = 1'b0;
            end
            bus.bitPulse = 1'b1;
            if (k == poke_at) bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.completeTx === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (n < 128) begin
                bits[n] = bus.dOut;
                stf[n]  = bus.stuffBit;
            end
            last = bus.dOut;
            n++;
        end
        bus.bitPulse = 1'b0;
        check("dout_stable_between_pulses", 128'(stable), 128'(1));
        check("complete_seen", 128'(ok), 128'(1));
        if (ok) begin
            check("dout_recessive_at_complete", 128'(bus.dOut), 128'(1));
            check("busy_low_at_complete", 128'(bus.busy), 128'(0));
            @(negedge clk);
            check("complete_one_cycle", 128'(bus.completeTx), 128'(0));
        end
    endtask

    task automatic frame_vs_model(input string tag, input logic [10:0] id, input logic [3:0] sz,
                                  input logic [63:0] d, input int gap, input int poke_at);
        logic [127:0] bits, stf, eb, es;
        int n, en;
        run_frame(id, sz, d, gap, poke_at, bits, stf, n);
        model(id, sz, d, eb, es, en);
        check({tag, "_len"}, 128'(n), 128'(en));
        check({tag, "_bits"}, bits, eb);
        check({tag, "_stuff"}, stf, es);
    endtask

    typedef struct {
        logic [10:0] id;
        logic [3:0]  sz;
        logic [63:0] d;
        int          len;
        logic [63:0] pat;     // first transmitted bit at pat[len-1]
        int          nstuff;
        int          gap;
        int          poke;
    } vec_t;

`ifdef CAN_CRC_EN
    localparam int NT = 1;
`else
    localparam int NT = 3;
`endif
    vec_t tab[NT];

    initial begin
        logic [127:0] bits, stf, expv, eb, es;
        int n, en;
        bit seen_done;

`ifdef CAN_CRC_EN
        tab[0] = '{11'h000, 4'd0, 64'd0, 41, 64'({{6{6'b000001}}, 5'b00001}), 6, 0, -1};
`else
        tab[0] = '{11'h000, 4'd0, 64'd0, 22, 64'b0000010000010000010000, 3, 0, -1};
        tab[1] = '{11'h7FF, 4'd0, 64'd0, 22, 64'b0111110111110100000100, 3, 7, 5};
        tab[2] = '{11'h555, 4'd1, 64'hE000_0000_0000_0000, 29,
                   64'b01010101010100000101111000001, 2, 1, -1};
`endif

        reset = 1'b1;
        bus.enable = 1'b0; bus.start = 1'b0; bus.bitPulse = 1'b0;
        bus.msgId = '0; bus.msgSize = '0; bus.dataIn = '0;
        repeat (3) @(negedge clk);
        check("reset_dout", 128'(bus.dOut), 128'(1));
        check("reset_busy", 128'(bus.busy), 128'(0));
        check("reset_complete", 128'(bus.completeTx), 128'(0));
        check("reset_stuff", 128'(bus.stuffBit), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        // Hand-derived frames.
        for (int t = 0; t < NT; t++) begin
            run_frame(tab[t].id, tab[t].sz, tab[t].d, tab[t].gap, tab[t].poke, bits, stf, n);
            expv = '0;
            for (int k = 0; k < tab[t].len; k++) expv[k] = tab[t].pat[tab[t].len-1-k];
            check($sformatf("tab%0d_len", t), 128'(n), 128'(tab[t].len));
            check($sformatf("tab%0d_bits", t), bits, expv);
            check($sformatf("tab%0d_nstuff", t), 128'($countones(stf)), 128'(tab[t].nstuff));
            model(tab[t].id, tab[t].sz, tab[t].d, eb, es, en);
            check($sformatf("tab%0d_model_stuff", t), stf, es);
        end

        // start with enable low is ignored.
        @(negedge clk);
        bus.enable = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) begin
            bus.bitPulse = 1'b1;
            @(negedge clk);
        end
        bus.bitPulse = 1'b0;
        check("disabled_busy", 128'(bus.busy), 128'(0));
        check("disabled_dout", 128'(bus.dOut), 128'(1));

        // Reset at bit 10 aborts with no completeTx; a fresh frame then starts from SOF.
        @(negedge clk);
        bus.enable = 1'b1; bus.msgId = 11'h123; bus.msgSize = 4'd2; bus.dataIn = 64'hA5C3_0000_0000_0000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen_done = 1'b0;
        repeat (10) begin
            bus.bitPulse = 1'b1;
            @(negedge clk);
            if (bus.completeTx === 1'b1) seen_done = 1'b1;
        end
        bus.bitPulse = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_dout", 128'(bus.dOut), 128'(1));
        check("abort_busy", 128'(bus.busy), 128'(0));
        repeat (4) begin
            bus.bitPulse = 1'b1;
            @(negedge clk);
            if (bus.completeTx === 1'b1) seen_done = 1'b1;
        end
        bus.bitPulse = 1'b0;
        check("abort_no_complete", 128'(seen_done), 128'(0));
        frame_vs_model("after_abort", 11'h123, 4'd2, 64'hA5C3_0000_0000_0000, 0, -1);

        // DLC above MAX_BYTES is clamped in length but sent as given.
        frame_vs_model("dlc15", 11'h0F0, 4'd15, 64'h0000_FFFF_0000_FFFF, 1, 20);

        // Random frames.
        for (int r = 0; r < 25; r++) begin
            frame_vs_model($sformatf("rnd%0d", r), 11'($urandom), 4'($urandom),
                           {$urandom, $urandom}, -1, int'($urandom_range(0, 60)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_checks);
        $fatal(1);
    end
endmodule
